// File: rtl/npc_pkg.sv
// Shared definitions for the issue stage: ALU select codes, default widths,
// the buffered-op record and a helper that decides whether a select code is defined.
package npc_pkg;

   localparam int N_DEF    = 32;
   localparam int RIDX_DEF = 5;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_OR  = 4'b0111;
   localparam logic [3:0] ALU_XOR = 4'b1000;
   localparam logic [3:0] ALU_LT  = 4'b1001;
   localparam logic [3:0] ALU_EQ  = 4'b1010;

   typedef struct packed {
      logic [3:0]          sel;
      logic [RIDX_DEF-1:0] rs1;
      logic [RIDX_DEF-1:0] rs2;
      logic [N_DEF-1:0]    rs1_val;
      logic [N_DEF-1:0]    rs2_val;
      logic [N_DEF-1:0]    pc;
      logic [N_DEF-1:0]    imm;
      logic                a_pc;
      logic                b_imm;
      logic [RIDX_DEF-1:0] rd;
   } entry_t;

   function automatic logic alu_sel_legal(input logic [3:0] sel);
      case (sel)
         ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_AND,
         ALU_OR, ALU_XOR, ALU_LT, ALU_EQ: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/exu_issue_entry.sv
// One skid-buffer slot: stores a decoded op, keeps its register operands fresh
// against the writeback port, and presents its already-selected ALU operands.
module issue_entry #(
   parameter int N    = 32,
   parameter int RIDX = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            valid_i,
   input  logic [3:0]      sel_i,
   input  logic [RIDX-1:0] rs1_i,
   input  logic [RIDX-1:0] rs2_i,
   input  logic [N-1:0]    rs1_val_i,
   input  logic [N-1:0]    rs2_val_i,
   input  logic [N-1:0]    pc_i,
   input  logic [N-1:0]    imm_i,
   input  logic            a_pc_i,
   input  logic            b_imm_i,
   input  logic [RIDX-1:0] rd_i,
   input  logic            wb_valid_i,
   input  logic [RIDX-1:0] wb_rd_i,
   input  logic [N-1:0]    wb_data_i,
   output logic [N-1:0]    a_o,
   output logic [N-1:0]    b_o,
   output logic [3:0]      sel_o,
   output logic [RIDX-1:0] rd_o
);

   logic [3:0]      sel_q;
   logic [RIDX-1:0] rs1_q, rs2_q, rd_q;
   logic [N-1:0]    rs1_val_q, rs2_val_q, pc_q, imm_q;
   logic            a_pc_q, b_imm_q;

   // x0 is hardwired, so a writeback to index 0 never forwards.
   logic wb_live, in_hit1, in_hit2, st_hit1, st_hit2;
   assign wb_live = wb_valid_i && (wb_rd_i != '0);
   assign in_hit1 = wb_live && (wb_rd_i == rs1_i);
   assign in_hit2 = wb_live && (wb_rd_i == rs2_i);
   assign st_hit1 = wb_live && (wb_rd_i == rs1_q);
   assign st_hit2 = wb_live && (wb_rd_i == rs2_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         a_pc_q    <= 1'b0;
         b_imm_q   <= 1'b0;
      end else if (load_i) begin
         sel_q     <= sel_i;
         rs1_q     <= rs1_i;
         rs2_q     <= rs2_i;
         rd_q      <= rd_i;
         rs1_val_q <= in_hit1 ? wb_data_i : rs1_val_i;
         rs2_val_q <= in_hit2 ? wb_data_i : rs2_val_i;
         pc_q      <= pc_i;
         imm_q     <= imm_i;
         a_pc_q    <= a_pc_i;
         b_imm_q   <= b_imm_i;
      end else if (valid_i) begin
         if (st_hit1) rs1_val_q <= wb_data_i;
         if (st_hit2) rs2_val_q <= wb_data_i;
      end
   end

   assign a_o   = a_pc_q  ? pc_q  : rs1_val_q;
   assign b_o   = b_imm_q ? imm_q : rs2_val_q;
   assign sel_o = sel_q;
   assign rd_o  = rd_q;

endmodule

// File: rtl/exu_issue.sv
// ID->EX stage register: a two-slot skid buffer with bypass and flush that
// presents the head op's ALU operands, select and destination.
module exu_issue
   import npc_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int RIDX = RIDX_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_sel,
   input  logic [RIDX-1:0] in_rs1,
   input  logic [RIDX-1:0] in_rs2,
   input  logic [N-1:0]    in_rs1_val,
   input  logic [N-1:0]    in_rs2_val,
   input  logic [N-1:0]    in_pc,
   input  logic [N-1:0]    in_imm,
   input  logic            in_a_pc,
   input  logic            in_b_imm,
   input  logic [RIDX-1:0] in_rd,
   input  logic            wb_valid,
   input  logic [RIDX-1:0] wb_rd,
   input  logic [N-1:0]    wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    alu_a,
   output logic [N-1:0]    alu_b,
   output logic [3:0]      alu_sel,
   output logic [RIDX-1:0] out_rd,
   output logic            out_illegal
);

   logic [1:0] count_q, count_d;
   logic       head_q, head_d, tail_q, tail_d;
   logic       push, pop;

   logic [N-1:0]    ent_a   [2];
   logic [N-1:0]    ent_b   [2];
   logic [3:0]      ent_sel [2];
   logic [RIDX-1:0] ent_rd  [2];

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic ent_load, ent_valid;
      // A flushed push must not overwrite a slot, even though it is discarded anyway.
      assign ent_load  = push && !flush && (tail_q == 1'(gi));
      assign ent_valid = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(gi)));

      issue_entry #(.N(N), .RIDX(RIDX)) u_entry (
         .clk        (clk),
         .rst        (rst),
         .load_i     (ent_load),
         .valid_i    (ent_valid),
         .sel_i      (in_sel),
         .rs1_i      (in_rs1),
         .rs2_i      (in_rs2),
         .rs1_val_i  (in_rs1_val),
         .rs2_val_i  (in_rs2_val),
         .pc_i       (in_pc),
         .imm_i      (in_imm),
         .a_pc_i     (in_a_pc),
         .b_imm_i    (in_b_imm),
         .rd_i       (in_rd),
         .wb_valid_i (wb_valid),
         .wb_rd_i    (wb_rd),
         .wb_data_i  (wb_data),
         .a_o        (ent_a[gi]),
         .b_o        (ent_b[gi]),
         .sel_o      (ent_sel[gi]),
         .rd_o       (ent_rd[gi])
      );
   end

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = 2'd0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end else begin
         if (push) tail_d = ~tail_q;
         if (pop)  head_d = ~head_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign alu_a       = ent_a[head_q];
   assign alu_b       = ent_b[head_q];
   assign alu_sel     = ent_sel[head_q];
   assign out_rd      = ent_rd[head_q];
   assign out_illegal = out_valid && !alu_sel_legal(alu_sel);

endmodule

// File: tb/tb_exu_issue.sv
// Self-checking bench for exu_issue: directed sequences, a select-code table,
// and a randomized run against a queue-based reference model.
module tb_exu_issue;
   import npc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  in_sel;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_val, in_rs2_val, in_pc, in_imm;
   logic        in_a_pc, in_b_imm;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_sel;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   exu_issue dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_pc(in_pc), .in_imm(in_imm), .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_rd(in_rd),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_sel = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_val = 0; in_rs2_val = 0; in_pc = 0; in_imm = 0;
      in_a_pc = 0; in_b_imm = 0;
      wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
   endtask

   task automatic offer(input logic [3:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                        input logic [31:0] imm, input logic apc, input logic bimm,
                        input logic [4:0] rd);
      in_valid = 1; in_sel = sel; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1;
      in_rs2_val = v2; in_pc = pc; in_imm = imm; in_a_pc = apc; in_b_imm = bimm; in_rd = rd;
   endtask

   // Reference: membership in the list of defined ALU codes.
   function automatic logic model_legal(input logic [3:0] s);
      int defined [9] = '{0, 1, 2, 3, 6, 7, 8, 9, 10};
      foreach (defined[k]) if (int'(s) == defined[k]) return 1'b1;
      return 1'b0;
   endfunction

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] rs1_val, rs2_val, pc, imm;
      logic        a_pc, b_imm;
      logic [31:0] exp_a, exp_b;
      logic        exp_ill;
   } vec_t;

   vec_t   vt [16];
   entry_t q [$];

   initial begin
      logic [15:0] ill_mask;
      ill_mask = 16'b1111_1000_0011_0000;
      for (int i = 0; i < 16; i++) begin
         vt[i].sel     = 4'(i);
         vt[i].rs1_val = 32'h100 + i;
         vt[i].pc      = 32'h200 + i;
         vt[i].rs2_val = 32'h300 + i;
         vt[i].imm     = 32'h400 + i;
         vt[i].a_pc    = i[0];
         vt[i].b_imm   = i[1];
         vt[i].exp_a   = i[0] ? 32'h200 + i : 32'h100 + i;
         vt[i].exp_b   = i[1] ? 32'h400 + i : 32'h300 + i;
         vt[i].exp_ill = ill_mask[i];
      end

      // Reset
      idle(); out_ready = 0; rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_alu_a", alu_a, 0);
      chk("reset_alu_b", alu_b, 0);
      chk("reset_alu_sel", alu_sel, 0);
      chk("reset_out_rd", out_rd, 0);
      chk("reset_illegal", out_illegal, 0);

      // Single add op, one-cycle latency, then drained
      @(negedge clk);
      out_ready = 1;
      offer(ALU_ADD, 5'd1, 5'd0, 32'd5, 32'd0, 32'h40, 32'd3, 1'b0, 1'b1, 5'd1);
      chk("single_not_zero_latency", out_valid, 0);
      @(negedge clk); idle();
      chk("single_valid", out_valid, 1);
      chk("single_a", alu_a, 5);
      chk("single_b", alu_b, 3);
      chk("single_sel", alu_sel, 0);
      @(negedge clk);
      chk("single_drained", out_valid, 0);
      $display("single op: a=0x%0h b=0x%0h", 5, 3);

      // Backpressure with three ops
      out_ready = 0;
      offer(ALU_SUB, 5'd0, 5'd0, 32'h11, 0, 0, 0, 1'b0, 1'b0, 5'd1);
      chk("bp_ready0", in_ready, 1);
      @(negedge clk);
      offer(ALU_SUB, 5'd0, 5'd0, 32'h22, 0, 0, 0, 1'b0, 1'b0, 5'd2);
      chk("bp_ready1", in_ready, 1);
      chk("bp_head1", out_rd, 1);
      @(negedge clk);
      offer(ALU_SUB, 5'd0, 5'd0, 32'h33, 0, 0, 0, 1'b0, 1'b0, 5'd3);
      chk("bp_full", in_ready, 0);
      @(negedge clk);
      chk("bp_still_full", in_ready, 0);
      chk("bp_head_held", out_rd, 1);
      chk("bp_head_a", alu_a, 32'h11);
      out_ready = 1;
      @(negedge clk);
      chk("bp_pop1_rd", out_rd, 2);
      chk("bp_pop1_a", alu_a, 32'h22);
      chk("bp_ready_after_pop", in_ready, 1);
      @(negedge clk); idle();
      chk("bp_pop2_rd", out_rd, 3);
      chk("bp_pop2_a", alu_a, 32'h33);
      chk("bp_pop2_valid", out_valid, 1);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);
      $display("backpressure: three ops drained in order");

      // Bypass into a buffered entry
      out_ready = 0;
      offer(ALU_ADD, 5'd4, 5'd0, 32'h10, 0, 32'h500, 0, 1'b0, 1'b1, 5'd9);
      @(negedge clk); idle();
      chk("byp_before", alu_a, 32'h10);
      wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h99;
      @(negedge clk); idle();
      chk("byp_after", alu_a, 32'h99);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      offer(ALU_ADD, 5'd0, 5'd0, 32'h10, 0, 0, 0, 1'b0, 1'b1, 5'd9);
      @(negedge clk); idle();
      wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h55;
      @(negedge clk); idle();
      chk("byp_x0_valid", out_valid, 1);
      chk("byp_x0_unchanged", alu_a, 32'h10);
      flush = 1;
      @(negedge clk); idle();
      chk("flush_empty", out_valid, 0);
      $display("bypass: buffered overwrite and x0 exclusion");

      // Same-cycle push and bypass, then flush at count 2
      offer(ALU_OR, 5'd0, 5'd7, 0, 32'd1, 0, 32'hFFFF, 1'b0, 1'b0, 5'd4);
      wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hAB;
      @(negedge clk); idle();
      chk("push_byp_b", alu_b, 32'hAB);
      offer(ALU_AND, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 5'd5);
      @(negedge clk);
      chk("pre_flush_full", in_ready, 0);
      offer(ALU_AND, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 5'd6);
      flush = 1;
      @(negedge clk); idle();
      chk("flush_full_valid", out_valid, 0);
      chk("flush_full_ready", in_ready, 1);
      @(negedge clk);
      chk("flush_full_no_ghost", out_valid, 0);
      offer(ALU_AND, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 5'd8);
      @(negedge clk);
      offer(ALU_AND, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 5'd9);
      flush = 1;
      @(negedge clk); idle();
      chk("flush_drops_push", out_valid, 0);
      $display("flush: buffered and same-cycle ops dropped");

      // Select-code table
      out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         offer(vt[i].sel, 0, 0, vt[i].rs1_val, vt[i].rs2_val, vt[i].pc, vt[i].imm,
               vt[i].a_pc, vt[i].b_imm, 5'(i));
         @(negedge clk); idle();
         chk("tbl_valid", out_valid, 1);
         chk("tbl_sel", alu_sel, vt[i].sel);
         chk("tbl_a", alu_a, vt[i].exp_a);
         chk("tbl_b", alu_b, vt[i].exp_b);
         chk("tbl_illegal", out_illegal, vt[i].exp_ill);
         $display("vector sel=%b a=0x%0h b=0x%0h illegal=%0b", vt[i].sel, alu_a, alu_b, out_illegal);
      end

      // Reset while holding an illegal op
      @(negedge clk);
      out_ready = 0;
      offer(4'b0101, 0, 0, 32'h77, 32'h88, 0, 0, 1'b0, 1'b0, 5'd3);
      @(negedge clk); idle();
      chk("ill_valid", out_valid, 1);
      chk("ill_flag", out_illegal, 1);
      rst = 1;
      @(negedge clk); rst = 0;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_a", alu_a, 0);
      chk("rst_mid_b", alu_b, 0);
      chk("rst_mid_sel", alu_sel, 0);
      chk("rst_mid_rd", out_rd, 0);
      chk("rst_mid_illegal", out_illegal, 0);

      // Randomized run against the queue model
      q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit p, o;
         @(negedge clk);
         in_valid   = 1'($urandom_range(0, 1));
         in_sel     = 4'($urandom_range(0, 15));
         in_rs1     = 5'($urandom_range(0, 3));
         in_rs2     = 5'($urandom_range(0, 3));
         in_rd      = 5'($urandom_range(0, 31));
         in_rs1_val = $urandom; in_rs2_val = $urandom;
         in_pc      = $urandom; in_imm     = $urandom;
         in_a_pc    = 1'($urandom_range(0, 1));
         in_b_imm   = 1'($urandom_range(0, 1));
         wb_valid   = 1'($urandom_range(0, 1));
         wb_rd      = 5'($urandom_range(0, 3));
         wb_data    = $urandom;
         flush      = ($urandom_range(0, 15) == 0);
         out_ready  = 1'($urandom_range(0, 1));

         chk("rnd_out_valid", out_valid, q.size() != 0);
         chk("rnd_in_ready", in_ready, q.size() < 2);
         chk("rnd_illegal", out_illegal, q.size() != 0 && !model_legal(q[0].sel));
         if (q.size() != 0) begin
            chk("rnd_a", alu_a, q[0].a_pc ? q[0].pc : q[0].rs1_val);
            chk("rnd_b", alu_b, q[0].b_imm ? q[0].imm : q[0].rs2_val);
            chk("rnd_sel", alu_sel, q[0].sel);
            chk("rnd_rd", out_rd, q[0].rd);
         end

         p = in_valid && (q.size() < 2);
         o = (q.size() != 0) && out_ready;
         if (flush) begin
            q.delete();
         end else begin
            foreach (q[k]) begin
               if (wb_valid && wb_rd != 0 && wb_rd == q[k].rs1) q[k].rs1_val = wb_data;
               if (wb_valid && wb_rd != 0 && wb_rd == q[k].rs2) q[k].rs2_val = wb_data;
            end
            if (o) void'(q.pop_front());
            if (p) begin
               entry_t e;
               e.sel = in_sel; e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
               e.rs1_val = (wb_valid && wb_rd != 0 && wb_rd == in_rs1) ? wb_data : in_rs1_val;
               e.rs2_val = (wb_valid && wb_rd != 0 && wb_rd == in_rs2) ? wb_data : in_rs2_val;
               e.pc = in_pc; e.imm = in_imm; e.a_pc = in_a_pc; e.b_imm = in_b_imm;
               q.push_back(e);
            end
         end
      end
      $display("random: 3000 cycles against reference model");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
